image_pipe_fifo: RTL and testbench
==================================

# image_pipe_fifo

Parametrised successor to the single-entry image pipeline stage: an elastic, registered stream stage with a DEPTH-entry FIFO between the input-side (is_*) and output-side (im_*) valid/busy/end interfaces. End-of-frame travels in-band with its last pixel, so end stays aligned with data under any backpressure. Upstream gets a registered busy with a programmable margin, and misuse is reported by a sticky overflow flag. It sits between image-pipe processing stages wherever more than one beat of slack is needed.

## Interface
- DW, 32: pixel/data width, ≥1.
- DEPTH, 4: FIFO entries; power of 2, ≥ BUSY_MARGIN+1.
- BUSY_MARGIN, 2: free entries reserved for beats upstream may still send after is_busy_out rises; ≥1.

- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- is_data_in  in  DW  input pixel.
- is_valid_in  in  1  input beat present.
- is_end_in  in  1  last pixel of frame; meaningful only with is_valid_in.
- is_busy_out  out  1  registered backpressure to upstream.
- im_data_out  out  DW  output pixel, registered.
- im_valid_out  out  1  output beat present, registered.
- im_end_out  out  1  output beat is frame end, registered.
- im_busy_in  in  1  downstream backpressure.
- fill_level  out  $clog2(DEPTH+1)  FIFO entries in use (excluding output register).
- ovf_err  out  1  sticky: beat offered while FIFO full.

## Operation
- FIFO entry = {end, data}, width DW+1; read/write pointers wrap modulo DEPTH; count held separately (0..DEPTH).
- Push: is_valid_in=1 and count<DEPTH, using count at start of cycle. A same-cycle pop frees no space for the push.
- Overflow: is_valid_in=1 and count==DEPTH. Beat dropped, ovf_err set until rst, FIFO unchanged.
- is_end_in without is_valid_in: ignored.
- Output register, edge with im_busy_in=1: hold im_data/valid/end unchanged.
- Output register, edge with im_busy_in=0 and count>0: pop head into it, im_valid_out=1, im_end_out=entry end bit.
- Output register, edge with im_busy_in=0 and count==0: im_valid_out=0, im_end_out=0, im_data_out=0.
- A beat is consumed downstream at an edge where im_valid_out=1 and im_busy_in=0.
- count_next = count + push − pop; fill_level = count (registered).
- is_busy_out <= (count_next ≥ DEPTH − BUSY_MARGIN).

## Timing
- Reset values: is_busy_out=0, im_data_out=0, im_valid_out=0, im_end_out=0, fill_level=0, ovf_err=0, pointers=0. Stats outputs are 0 when present.
- Reset mid-frame discards all stored and in-flight beats. First cycle after reset accepts input.
- Latency, empty FIFO and no busy: beat presented in cycle t is written at edge t and appears on im_* after edge t+1, i.e. 2 cycles.
- Throughput: 1 beat/cycle sustained while im_busy_in=0.
- is_busy_out lags the push that crosses threshold by one edge. Upstream must stop within BUSY_MARGIN beats of seeing it high, or overflow occurs.
- is_busy_out falls one edge after count_next drops below threshold.
- im_busy_in does not propagate combinationally to is_busy_out.

## Configuration
- IMAGE_PIPE_FIFO_STATS_EN defined: adds outputs frame_cnt [15:0] and last_frame_pix [31:0].
  - pix counter increments per consumed output beat.
  - On a consumed beat with im_end_out=1: last_frame_pix <= pix+1, pix <= 0, frame_cnt increments (wraps 0xFFFF→0).
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, single beat 0xA5A5_0001 with end=1, im_busy_in=0 → im_valid_out=1, im_end_out=1, data 0xA5A5_0001 exactly 2 cycles later, then valid=0 and data=0.
- DEPTH=4, BUSY_MARGIN=2, 8-beat burst 1..8, im_busy_in=1 throughout. Upstream honours busy with 1-cycle reaction → is_busy_out rises after 2nd push. Beats 1..4 stored, fill_level=4, ovf_err=0 (pushes beyond 4 only if upstream ignores busy).
- Same fill, then upstream forces beat 9 while full → ovf_err=1 and stays 1. Releasing im_busy_in drains exactly 1,2,3,4 in order, beat 9 never appears.
- Random im_busy_in toggling, 3 frames of 5, 1, 7 pixels → output order preserved, im_end_out only on pixels 5, 1, 7 of each frame. With STATS_EN: frame_cnt=3, last_frame_pix=7.
- rst asserted with fill_level=3 and im_valid_out=1 → next cycle all outputs 0, fill_level=0. Beat 0x55 after rst drops emerges 2 cycles later.
- Continuous input with im_busy_in=0 for 100 cycles → 100 beats out, is_busy_out never 1, fill_level ≤1.

Source files
------------

// File: rtl/image_pipe_fifo.sv
// ---------------------------------------------------------------------------
// image_pipe_fifo
//
// Elastic, registered stream stage for the image pipeline. A DEPTH-entry FIFO
// sits between the upstream (is_*) and downstream (im_*) valid/busy/end
// interfaces, followed by a registered output stage. End-of-frame is stored
// in-band with its pixel, so it can never drift away from its data under
// backpressure.
//
// Upstream backpressure (is_busy_out) is registered and raised early: it goes
// high once the FIFO holds DEPTH-BUSY_MARGIN or more entries. That leaves
// BUSY_MARGIN free slots for beats already in flight. Any beat offered while
// the FIFO is full is dropped, and the sticky ovf_err flag is set.
//
// Optional feature (macro IMAGE_PIPE_FIFO_STATS_EN):
//   adds frame_cnt and last_frame_pix, which count consumed frames and the
//   pixel count of the most recent frame.
//
// Parameters:
//   DW          pixel width (>= 1)
//   DEPTH       FIFO entries (power of 2, >= BUSY_MARGIN+1)
//   BUSY_MARGIN free entries reserved after is_busy_out rises (>= 1)
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   is_data_in      input pixel
//   is_valid_in     input beat present
//   is_end_in       input beat is the last pixel of its frame
//   is_busy_out     registered backpressure to upstream
//   im_data_out     registered output pixel
//   im_valid_out    registered output beat present
//   im_end_out      registered output end-of-frame
//   im_busy_in      downstream backpressure
//   fill_level      FIFO entries in use (the output register is not counted)
//   ovf_err         sticky: a beat was offered while the FIFO was full
//   frame_cnt       (stats only) frames consumed downstream, wraps at 16 bits
//   last_frame_pix  (stats only) pixel count of the last consumed frame
// ---------------------------------------------------------------------------
module image_pipe_fifo #(
    parameter int DW          = 32,
    parameter int DEPTH       = 4,
    parameter int BUSY_MARGIN = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DW-1:0]                is_data_in,
    input  logic                         is_valid_in,
    input  logic                         is_end_in,
    output logic                         is_busy_out,
    output logic [DW-1:0]                im_data_out,
    output logic                         im_valid_out,
    output logic                         im_end_out,
    input  logic                         im_busy_in,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic                         ovf_err
`ifdef IMAGE_PIPE_FIFO_STATS_EN
    ,
    output logic [15:0]                  frame_cnt,
    output logic [31:0]                  last_frame_pix
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(DEPTH - BUSY_MARGIN);

    // Each entry is {end, data}.
    logic [DW:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          overflow;

    // Both decisions use the count from the start of the cycle. A pop in the
    // same cycle does not make room for a push into a full FIFO.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        push       = 1'b0;
        pop        = 1'b0;
        overflow   = 1'b0;
        count_next = count;

        push     = is_valid_in && (count != DEPTH_C);
        overflow = is_valid_in && (count == DEPTH_C);
        pop      = !im_busy_in && (count != '0);

        unique case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: the storage array has no reset. Valid entries are tracked only by
    // the pointers and count, so clearing the data would cost logic and add
    // nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {is_end_in, is_data_in};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments only. Every
        // right-hand side then sees the values from before the edge, which
        // the count/pointer and output-register updates rely on.
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            is_busy_out  <= 1'b0;
            im_data_out  <= '0;
            im_valid_out <= 1'b0;
            im_end_out   <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflowing.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;

            // Built from count_next rather than im_busy_in, so there is no
            // combinational path from downstream busy to upstream busy.
            is_busy_out <= (count_next >= THRESH_C);

            if (overflow) begin
                ovf_err <= 1'b1;
            end

            // The output register holds while downstream is busy. Otherwise
            // it loads the FIFO head, or clears to an idle bubble when empty.
            if (!im_busy_in) begin
                if (count != '0) begin
                    im_data_out  <= mem[rd_ptr][DW-1:0];
                    im_end_out   <= mem[rd_ptr][DW];
                    im_valid_out <= 1'b1;
                end else begin
                    im_data_out  <= '0;
                    im_end_out   <= 1'b0;
                    im_valid_out <= 1'b0;
                end
            end
        end
    end

    assign fill_level = count;

`ifdef IMAGE_PIPE_FIFO_STATS_EN
    // A beat is consumed when it sits in the output register while
    // downstream is not busy.
    logic        consumed;
    logic [31:0] pix_cnt;

    assign consumed = im_valid_out && !im_busy_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt        <= '0;
            frame_cnt      <= '0;
            last_frame_pix <= '0;
        end else if (consumed) begin
            if (im_end_out) begin
                last_frame_pix <= pix_cnt + 32'd1;
                pix_cnt        <= '0;
                frame_cnt      <= frame_cnt + 16'd1;
            end else begin
                pix_cnt <= pix_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_image_pipe_fifo.sv
`timescale 1ns/1ps
module tb_image_pipe_fifo;

    localparam int DW          = 32;
    localparam int DEPTH       = 4;
    localparam int BUSY_MARGIN = 2;
    localparam int CW          = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] is_data_in = '0;
    logic          is_valid_in = 1'b0;
    logic          is_end_in = 1'b0;
    logic          is_busy_out;
    logic [DW-1:0] im_data_out;
    logic          im_valid_out;
    logic          im_end_out;
    logic          im_busy_in = 1'b0;
    logic [CW-1:0] fill_level;
    logic          ovf_err;
`ifdef IMAGE_PIPE_FIFO_STATS_EN
    logic [15:0]   frame_cnt;
    logic [31:0]   last_frame_pix;
`endif

    image_pipe_fifo #(.DW(DW), .DEPTH(DEPTH), .BUSY_MARGIN(BUSY_MARGIN)) dut (
        .clk            (clk),
        .rst            (rst),
        .is_data_in     (is_data_in),
        .is_valid_in    (is_valid_in),
        .is_end_in      (is_end_in),
        .is_busy_out    (is_busy_out),
        .im_data_out    (im_data_out),
        .im_valid_out   (im_valid_out),
        .im_end_out     (im_end_out),
        .im_busy_in     (im_busy_in),
        .fill_level     (fill_level),
        .ovf_err        (ovf_err)
`ifdef IMAGE_PIPE_FIFO_STATS_EN
        ,
        .frame_cnt      (frame_cnt),
        .last_frame_pix (last_frame_pix)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int consumed = 0;
    int mcount = 0;
    logic [DW:0] exp_q[$];

    // Scoreboard: accepted beats are queued in order; each consumed beat is
    // popped and compared. Sampled in the active region at the edge, which
    // gives the pre-edge values of both inputs and registered outputs.
    always @(posedge clk) begin
        logic [DW:0] exp_beat;
        bit push_m, pop_m;
        if (rst) begin
            exp_q.delete();
            mcount = 0;
        end else begin
            if (im_valid_out && !im_busy_in) begin
                consumed++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra_beat: got end=%b data=%h, required no beat",
                             im_end_out, im_data_out);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if ({im_end_out, im_data_out} !== exp_beat) begin
                        errors++;
                        $display("FAIL sb_beat: got end=%b data=%h, required end=%b data=%h",
                                 im_end_out, im_data_out, exp_beat[DW], exp_beat[DW-1:0]);
                    end
                end
            end
            push_m = is_valid_in && (mcount < DEPTH);
            pop_m  = !im_busy_in && (mcount > 0);
            if (push_m) exp_q.push_back({is_end_in, is_data_in});
            mcount = mcount + int'(push_m) - int'(pop_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        is_valid_in = 1'b0;
        is_end_in = 1'b0;
        is_data_in = '0;
        im_busy_in = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks += 6;
        if (is_busy_out !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", is_busy_out); end
        if (im_data_out !== '0) begin errors++; $display("FAIL rst_data: got %h required 0", im_data_out); end
        if (im_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", im_valid_out); end
        if (im_end_out !== 1'b0) begin errors++; $display("FAIL rst_end: got %b required 0", im_end_out); end
        if (fill_level !== '0) begin errors++; $display("FAIL rst_fill: got %0d required 0", fill_level); end
        if (ovf_err !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b required 0", ovf_err); end
`ifdef IMAGE_PIPE_FIFO_STATS_EN
        checks += 2;
        if (frame_cnt !== '0) begin errors++; $display("FAIL rst_frame_cnt: got %0d required 0", frame_cnt); end
        if (last_frame_pix !== '0) begin errors++; $display("FAIL rst_last_pix: got %0d required 0", last_frame_pix); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single();
        im_busy_in = 1'b0;
        is_valid_in = 1'b1;
        is_data_in = 32'hA5A5_0001;
        is_end_in = 1'b1;
        tick();
        is_valid_in = 1'b0;
        is_end_in = 1'b0;
        is_data_in = '0;
        checks++;
        if (im_valid_out !== 1'b0) begin errors++; $display("FAIL single_early: got valid %b required 0", im_valid_out); end
        tick();
        checks += 3;
        if (im_valid_out !== 1'b1) begin errors++; $display("FAIL single_valid: got %b required 1", im_valid_out); end
        if (im_end_out !== 1'b1) begin errors++; $display("FAIL single_end: got %b required 1", im_end_out); end
        if (im_data_out !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data: got %h required a5a50001", im_data_out); end
        tick();
        checks += 2;
        if (im_valid_out !== 1'b0) begin errors++; $display("FAIL single_after_valid: got %b required 0", im_valid_out); end
        if (im_data_out !== '0) begin errors++; $display("FAIL single_after_data: got %h required 0", im_data_out); end
    endtask

    // Upstream stops BUSY_MARGIN beats after it first sees is_busy_out high.
    task automatic test_fill();
        int sent = 0;
        int seen = 0;
        do_reset();
        im_busy_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (seen >= BUSY_MARGIN) begin
                is_valid_in = 1'b0;
                is_end_in = 1'b0;
            end else begin
                if (is_busy_out) seen++;
                is_valid_in = 1'b1;
                is_data_in = DW'(i);
                is_end_in = (i == 4);
                sent++;
            end
            tick();
            checks++;
            if (is_busy_out !== 1'(sent >= DEPTH - BUSY_MARGIN)) begin
                errors++;
                $display("FAIL fill_busy_%0d: got %b required %b", i, is_busy_out, sent >= DEPTH - BUSY_MARGIN);
            end
        end
        is_valid_in = 1'b0;
        is_end_in = 1'b0;
        checks += 3;
        if (sent !== 4) begin errors++; $display("FAIL fill_sent: got %0d beats sent required 4", sent); end
        if (fill_level !== CW'(4)) begin errors++; $display("FAIL fill_level: got %0d required 4", fill_level); end
        if (ovf_err !== 1'b0) begin errors++; $display("FAIL fill_ovf: got %b required 0", ovf_err); end
    endtask

    task automatic test_overflow();
        int base;
        is_valid_in = 1'b1;
        is_data_in = DW'(9);
        is_end_in = 1'b1;
        tick();
        is_valid_in = 1'b0;
        is_end_in = 1'b0;
        checks += 2;
        if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", ovf_err); end
        if (fill_level !== CW'(4)) begin errors++; $display("FAIL ovf_fill: got %0d required 4", fill_level); end
        base = consumed;
        im_busy_in = 1'b0;
        repeat (8) tick();
        checks += 4;
        if (consumed - base !== 4) begin errors++; $display("FAIL ovf_drain_cnt: got %0d beats required 4", consumed - base); end
        if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", ovf_err); end
        if (fill_level !== '0) begin errors++; $display("FAIL ovf_drain_fill: got %0d required 0", fill_level); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL ovf_sb_left: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_frames();
        int lens[3] = '{5, 1, 7};
        int guard = 0;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            int p = 0;
            while (p < lens[f] && guard < 500) begin
                im_busy_in = 1'($urandom_range(0, 1));
                if (!is_busy_out) begin
                    is_valid_in = 1'b1;
                    is_data_in = DW'((f + 1) * 256 + p + 1);
                    is_end_in = (p == lens[f] - 1);
                    p++;
                end else begin
                    is_valid_in = 1'b0;
                    is_end_in = 1'b0;
                end
                tick();
                guard++;
            end
        end
        is_valid_in = 1'b0;
        is_end_in = 1'b0;
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
            im_busy_in = 1'($urandom_range(0, 1));
            tick();
        end
        im_busy_in = 1'b0;
        tick();
        checks += 3;
        if (guard >= 500) begin errors++; $display("FAIL frames_stimulus_timeout: got %0d cycles required < 500", guard); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL frames_drain: got %0d pending required 0", exp_q.size()); end
        if (ovf_err !== 1'b0) begin errors++; $display("FAIL frames_ovf: got %b required 0", ovf_err); end
`ifdef IMAGE_PIPE_FIFO_STATS_EN
        checks += 2;
        if (frame_cnt !== 16'd3) begin errors++; $display("FAIL frames_cnt: got %0d required 3", frame_cnt); end
        if (last_frame_pix !== 32'd7) begin errors++; $display("FAIL frames_last_pix: got %0d required 7", last_frame_pix); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        im_busy_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            is_valid_in = 1'b1;
            is_data_in = DW'(32'h100 + i);
            is_end_in = 1'b0;
            tick();
        end
        is_valid_in = 1'b0;
        im_busy_in = 1'b0;
        tick();
        im_busy_in = 1'b1;
        checks += 2;
        if (fill_level !== CW'(3)) begin errors++; $display("FAIL mid_pre_fill: got %0d required 3", fill_level); end
        if (im_valid_out !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b required 1", im_valid_out); end
        rst = 1'b1;
        tick();
        checks += 5;
        if (fill_level !== '0) begin errors++; $display("FAIL mid_fill: got %0d required 0", fill_level); end
        if (im_valid_out !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b required 0", im_valid_out); end
        if (im_data_out !== '0) begin errors++; $display("FAIL mid_data: got %h required 0", im_data_out); end
        if (is_busy_out !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b required 0", is_busy_out); end
        if (ovf_err !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b required 0", ovf_err); end
        rst = 1'b0;
        im_busy_in = 1'b0;
        is_valid_in = 1'b1;
        is_data_in = DW'(32'h55);
        tick();
        is_valid_in = 1'b0;
        is_data_in = '0;
        tick();
        checks += 3;
        if (im_valid_out !== 1'b1) begin errors++; $display("FAIL mid_after_valid: got %b required 1", im_valid_out); end
        if (im_data_out !== DW'(32'h55)) begin errors++; $display("FAIL mid_after_data: got %h required 55", im_data_out); end
        if (im_end_out !== 1'b0) begin errors++; $display("FAIL mid_after_end: got %b required 0", im_end_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        int base;
        int busy_hits = 0;
        int fill_hits = 0;
        do_reset();
        base = consumed;
        for (int i = 0; i < 100; i++) begin
            is_valid_in = 1'b1;
            is_data_in = DW'(1000 + i);
            is_end_in = (i == 99);
            tick();
            if (is_busy_out !== 1'b0) busy_hits++;
            if (fill_level > CW'(1)) fill_hits++;
        end
        is_valid_in = 1'b0;
        is_end_in = 1'b0;
        repeat (3) tick();
        checks += 4;
        if (busy_hits !== 0) begin errors++; $display("FAIL stream_busy: got %0d busy cycles required 0", busy_hits); end
        if (fill_hits !== 0) begin errors++; $display("FAIL stream_fill: got %0d cycles above 1 required 0", fill_hits); end
        if (consumed - base !== 100) begin errors++; $display("FAIL stream_count: got %0d beats required 100", consumed - base); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL stream_sb_left: got %0d pending required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_overflow();
        test_frames();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
